card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
Deck-based card source for the blackjack controller. It holds a 52-card deck, shuffles it with an LFSR-driven Fisher-Yates pass, and hands out one card per request. It sits directly upstream of top, which requests cards in the dealer, player, double and split phases. It replaces ad-hoc random card values with a real finite deck and gives a deterministic mode for directed benches.

Parameters:
SEED, 16'hACE1, initial LFSR state; a value of 0 is replaced by 16'hACE1.
SHUFFLE_EN, 1, 1 = shuffle after fill; 0 = skip shuffle and deal the deck in fill order (directed tests).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
shuffle_req  in  1  one-cycle pulse; rebuilds and reshuffles the whole deck
card_req  in  1  one-cycle pulse; request the next card
card_valid  out  1  one-cycle pulse; card_value and card_rank are valid
card_value  out  6  blackjack value: A=11, 2-10 face value, J/Q/K=10
card_rank  out  4  rank 1..13 (A=1, K=13), for display
ready  out  1  high only in READY
cards_left  out  6  undealt cards, 0..52
busy  out  1  high in FILL or SHUFFLE

Behaviour:
- Storage: deck[0..51], 4-bit rank per entry. deal_ptr is 6 bits. cards_left = 52 - deal_ptr.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It steps every cycle in SHUFFLE only.
- Reset (reset=0, async):
  - state=FILL, idx=0, deal_ptr=0, pending=0, LFSR=SEED.
  - Outputs: card_valid=0, card_value=0, card_rank=0, ready=0, cards_left=52, busy=1.
  - Deck contents are don't-care.
- FILL:
  - Each cycle writes deck[idx] = (idx mod 13)+1 and increments idx.
  - After idx=51 is written, goes to SHUFFLE with i=51 if SHUFFLE_EN, else to READY.
  - Duration is exactly 52 cycles.
- SHUFFLE, one attempt per cycle:
  - j = lfsr[5:0] & mask(i), where mask is the smallest 2^k-1 >= i.
  - If j <= i: swap deck[i] and deck[j] in the same cycle (j==i is a no-op), then decrement i.
  - If j > i: reject, hold i, and retry next cycle.
  - After the swap at i=1, go to READY with deal_ptr=0.
- READY + card_req:
  - On the next edge, card_rank=deck[deal_ptr], card_value=map(rank), card_valid=1 for exactly one cycle, deal_ptr++.
  - Latency is 1 cycle.
  - card_value and card_rank hold their last values after card_valid drops.
- Back-to-back card_req on consecutive cycles in READY: each one is served, one card per cycle.
- card_req while busy:
  - Latched into pending (1-deep); a further request while pending=1 is dropped.
  - pending is served on the first READY cycle, which is 1 cycle after entering READY, and then cleared.
- Deck exhaustion: card_req with cards_left=0 sets pending and starts FILL automatically. The card is delivered after the reshuffle.
- shuffle_req in any state (including mid-SHUFFLE):
  - Goes to FILL with idx=0 and deal_ptr=0.
  - The LFSR is not reseeded; it continues from its current state.
- shuffle_req and card_req in the same cycle: the shuffle wins and card_req becomes pending.
- ready=0 in FILL/SHUFFLE. card_valid is never asserted outside the READY-to-deal transition.

Test Plan:
1. SHUFFLE_EN=0, reset low 2 cycles then high.
   - busy=1 for 52 cycles, then ready=1 and cards_left=52.
   - Three card_req pulses give card_value 11, 2, 3 and card_rank 1, 2, 3, each card_valid one cycle after its req; cards_left=49.
2. SHUFFLE_EN=0, deal 13 cards.
   - Ranks 11..13 give card_value 10, 10, 10.
   - The 14th card is rank 1, value 11.
3. SHUFFLE_EN=1, SEED=16'hACE1.
   - Deal all 52 cards: each rank 1..13 appears exactly 4 times and the order differs from fill order.
   - The 53rd card_req triggers busy=1, then exactly one card_valid after the reshuffle; cards_left=51.
4. card_req during FILL, plus a second card_req 3 cycles later.
   - Exactly one card_valid, issued 1 cycle after ready rises.
5. shuffle_req and card_req in the same cycle in READY with cards_left=40.
   - cards_left=52 immediately, busy=1, then one card is delivered after ready and cards_left=51.
6. Pull reset low mid-SHUFFLE.
   - Outputs return to reset values immediately (async), without waiting for a clock edge.
   - After release, the FILL+SHUFFLE sequence repeats identically to the post-power-up run (same first 5 cards).

Source files
------------

// File: rtl/card_dealer.sv
// Finite 52-card deck: fills in rank order, LFSR Fisher-Yates shuffle, deals one card per request.
// Latency: card 1 cycle after request in READY; requests while busy are held 1-deep until READY.
// Backpressure: none; a second request while one is pending is dropped, shuffle_req always wins.
module card_dealer #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic        SHUFFLE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shuffle_req,
    input  logic       card_req,
    output logic       card_valid,
    output logic [5:0] card_value,
    output logic [3:0] card_rank,
    output logic       ready,
    output logic [5:0] cards_left,
    output logic       busy
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {ST_FILL, ST_SHUFFLE, ST_READY} state_t;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  deal_ptr_q, deal_ptr_d;
    logic        pending_q, pending_d;
    logic [15:0] lfsr_q, lfsr_d, lfsr_step;
    logic        fill_en, swap_en, deal_en;
    logic [5:0]  mask, j, fill_tmp;
    logic [3:0]  fill_rank;
    logic [3:0]  deck [52];

    function automatic logic [5:0] rank_to_value(input logic [3:0] r);
        if (r == 4'd1)
            return 6'd11;
        else if (r >= 4'd11)
            return 6'd10;
        else
            return {2'b00, r};
    endfunction

    // Galois form of x^16+x^14+x^13+x^11+1
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    always_comb begin
        mask = 6'd63;
        if (idx_q <= 6'd1)
            mask = 6'd1;
        else if (idx_q <= 6'd3)
            mask = 6'd3;
        else if (idx_q <= 6'd7)
            mask = 6'd7;
        else if (idx_q <= 6'd15)
            mask = 6'd15;
        else if (idx_q <= 6'd31)
            mask = 6'd31;
        j = lfsr_q[5:0] & mask;
    end

    // (idx mod 13) + 1 without a divider
    always_comb begin
        fill_tmp = idx_q + 6'd1;
        if (idx_q >= 6'd39)
            fill_tmp = idx_q - 6'd38;
        else if (idx_q >= 6'd26)
            fill_tmp = idx_q - 6'd25;
        else if (idx_q >= 6'd13)
            fill_tmp = idx_q - 6'd12;
        fill_rank = fill_tmp[3:0];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        deal_ptr_d = deal_ptr_q;
        pending_d  = pending_q;
        lfsr_d     = (state_q == ST_SHUFFLE) ? lfsr_step : lfsr_q;
        fill_en    = 1'b0;
        swap_en    = 1'b0;
        deal_en    = 1'b0;
        case (state_q)
            ST_FILL: begin
                fill_en = 1'b1;
                if (card_req)
                    pending_d = 1'b1;
                if (idx_q == 6'd51)
                    state_d = SHUFFLE_EN ? ST_SHUFFLE : ST_READY;
                else
                    idx_d = idx_q + 6'd1;
            end
            ST_SHUFFLE: begin
                if (card_req)
                    pending_d = 1'b1;
                if (j <= idx_q) begin
                    swap_en = 1'b1;
                    if (idx_q == 6'd1) begin
                        state_d    = ST_READY;
                        deal_ptr_d = 6'd0;
                    end else begin
                        idx_d = idx_q - 6'd1;
                    end
                end
            end
            ST_READY: begin
                if (card_req || pending_q) begin
                    if (deal_ptr_q == 6'd52) begin
                        // Deck exhausted: rebuild and deliver this card afterwards
                        state_d    = ST_FILL;
                        idx_d      = 6'd0;
                        deal_ptr_d = 6'd0;
                        pending_d  = 1'b1;
                    end else begin
                        deal_en    = 1'b1;
                        deal_ptr_d = deal_ptr_q + 6'd1;
                        pending_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
        if (shuffle_req) begin
            state_d    = ST_FILL;
            idx_d      = 6'd0;
            deal_ptr_d = 6'd0;
            pending_d  = pending_q | card_req;
            swap_en    = 1'b0;
            deal_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_FILL;
            idx_q      <= 6'd0;
            deal_ptr_q <= 6'd0;
            pending_q  <= 1'b0;
            lfsr_q     <= SEED_EFF;
            card_valid <= 1'b0;
            card_rank  <= 4'd0;
            card_value <= 6'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            deal_ptr_q <= deal_ptr_d;
            pending_q  <= pending_d;
            lfsr_q     <= lfsr_d;
            card_valid <= deal_en;
            if (deal_en) begin
                card_rank  <= deck[deal_ptr_q];
                card_value <= rank_to_value(deck[deal_ptr_q]);
            end
        end
    end

    // Deck contents are not reset; FILL always rebuilds them before use
    always_ff @(posedge clk) begin
        if (fill_en) begin
            deck[idx_q] <= fill_rank;
        end else if (swap_en) begin
            deck[idx_q] <= deck[j];
            deck[j]     <= deck[idx_q];
        end
    end

    assign ready      = (state_q == ST_READY);
    assign busy       = (state_q != ST_READY);
    assign cards_left = 6'd52 - deal_ptr_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: dut0 deals in fill order, dut1 shuffles from SEED 16'hACE1.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n;
    logic       shuffle_req0, card_req0, shuffle_req1, card_req1;
    logic       card_valid0, card_valid1, ready0, ready1, busy0, busy1;
    logic [5:0] card_value0, card_value1, cards_left0, cards_left1;
    logic [3:0] card_rank0, card_rank1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_lfsr;
    int          m_deck [52];
    int          exp1   [52];
    int          exp2   [52];
    int          cnt    [14];

    always #5 clk = ~clk;

    card_dealer #(.SEED(16'hACE1), .SHUFFLE_EN(1'b0)) dut0 (
        .clk(clk), .reset(rst0_n), .shuffle_req(shuffle_req0), .card_req(card_req0),
        .card_valid(card_valid0), .card_value(card_value0), .card_rank(card_rank0),
        .ready(ready0), .cards_left(cards_left0), .busy(busy0)
    );

    card_dealer #(.SEED(16'hACE1), .SHUFFLE_EN(1'b1)) dut1 (
        .clk(clk), .reset(rst1_n), .shuffle_req(shuffle_req1), .card_req(card_req1),
        .card_valid(card_valid1), .card_value(card_value1), .card_rank(card_rank1),
        .ready(ready1), .cards_left(cards_left1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int value_of(input int r);
        return (r == 1) ? 11 : ((r >= 11) ? 10 : r);
    endfunction

    // Reference Fisher-Yates with rejection, one attempt per LFSR step
    task automatic model_shuffle();
        int i, j, m, t, guard;
        for (int k = 0; k < 52; k++) m_deck[k] = k % 13 + 1;
        i = 51;
        guard = 0;
        while (i >= 1 && guard < 100000) begin
            m = 1;
            while (m < i) m = m * 2 + 1;
            j = int'(m_lfsr[5:0]) & m;
            if (j <= i) begin
                t = m_deck[i]; m_deck[i] = m_deck[j]; m_deck[j] = t;
                i--;
            end
            m_lfsr = lfsr_adv(m_lfsr);
            guard++;
        end
    endtask

    task automatic deal(input int sel, output logic v, output logic [3:0] r, output logic [5:0] val);
        if (sel == 0) card_req0 = 1'b1; else card_req1 = 1'b1;
        step();
        card_req0 = 1'b0;
        card_req1 = 1'b0;
        v   = (sel == 0) ? card_valid0 : card_valid1;
        r   = (sel == 0) ? card_rank0  : card_rank1;
        val = (sel == 0) ? card_value0 : card_value1;
    endtask

    task automatic wait_ready(input int sel, input string tag);
        int n = 0;
        while (!((sel == 0) ? ready0 : ready1) && n < 2000) begin
            step();
            n++;
        end
        check(tag, (sel == 0) ? ready0 : ready1, 1);
    endtask

    initial begin
        logic       v;
        logic [3:0] r;
        logic [5:0] val;
        int         n, vcount, diff;

        rst0_n = 1'b1; rst1_n = 1'b1;
        shuffle_req0 = 1'b0; card_req0 = 1'b0;
        shuffle_req1 = 1'b0; card_req1 = 1'b0;
        #2;
        rst0_n = 1'b0; rst1_n = 1'b0;
        step(); step();

        // Reset values
        check("rst_valid", card_valid0, 0);
        check("rst_value", card_value0, 0);
        check("rst_rank", card_rank0, 0);
        check("rst_ready", ready0, 0);
        check("rst_left", cards_left0, 52);
        check("rst_busy", busy0, 1);

        // 1: fill duration and first three cards in fill order
        rst0_n = 1'b1;
        n = 0;
        while (busy0 && n < 200) begin
            step();
            n++;
        end
        check("fill_cycles", n, 52);
        check("t1_ready", ready0, 1);
        check("t1_left", cards_left0, 52);
        for (int k = 1; k <= 3; k++) begin
            deal(0, v, r, val);
            check("t1_valid", v, 1);
            check("t1_rank", r, k);
            check("t1_value", val, value_of(k));
        end
        step();
        check("t1_valid_drop", card_valid0, 0);
        check("t1_rank_hold", card_rank0, 3);
        check("t1_left49", cards_left0, 49);

        // 2: cards 4..14, face cards worth 10, wrap to ace
        for (int k = 4; k <= 14; k++) begin
            deal(0, v, r, val);
            check("t2_valid", v, 1);
            check("t2_rank", r, (k - 1) % 13 + 1);
            check("t2_value", val, value_of((k - 1) % 13 + 1));
        end
        check("t2_left", cards_left0, 38);

        // 4: two requests during FILL yield exactly one card after ready
        shuffle_req0 = 1'b1;
        step();
        shuffle_req0 = 1'b0;
        check("t4_left52", cards_left0, 52);
        check("t4_busy", busy0, 1);
        check("t4_ready0", ready0, 0);
        step(); step(); step();
        vcount = 0;
        card_req0 = 1'b1;
        step();
        card_req0 = 1'b0;
        vcount += int'(card_valid0);
        step();
        vcount += int'(card_valid0);
        step();
        vcount += int'(card_valid0);
        card_req0 = 1'b1;
        step();
        card_req0 = 1'b0;
        n = 0;
        while (!ready0 && n < 200) begin
            vcount += int'(card_valid0);
            step();
            n++;
        end
        check("t4_ready", ready0, 1);
        check("t4_no_early", vcount, 0);
        check("t4_valid_at_ready", card_valid0, 0);
        step();
        check("t4_valid", card_valid0, 1);
        check("t4_rank", card_rank0, 1);
        check("t4_value", card_value0, 11);
        check("t4_left", cards_left0, 51);
        vcount = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            vcount += int'(card_valid0);
        end
        check("t4_single", vcount, 0);

        // 5: shuffle_req and card_req together with 40 cards left
        for (int k = 2; k <= 12; k++) begin
            deal(0, v, r, val);
            check("t5_pre_rank", r, k);
        end
        check("t5_left40", cards_left0, 40);
        shuffle_req0 = 1'b1;
        card_req0 = 1'b1;
        step();
        shuffle_req0 = 1'b0;
        card_req0 = 1'b0;
        check("t5_left52", cards_left0, 52);
        check("t5_busy", busy0, 1);
        check("t5_no_valid", card_valid0, 0);
        wait_ready(0, "t5_ready");
        check("t5_valid_at_ready", card_valid0, 0);
        step();
        check("t5_valid", card_valid0, 1);
        check("t5_rank", card_rank0, 1);
        check("t5_left51", cards_left0, 51);

        // 3: shuffled deck from SEED
        m_lfsr = 16'hACE1;
        model_shuffle();
        for (int k = 0; k < 52; k++) exp1[k] = m_deck[k];
        model_shuffle();
        for (int k = 0; k < 52; k++) exp2[k] = m_deck[k];
        for (int k = 0; k < 14; k++) cnt[k] = 0;
        rst1_n = 1'b1;
        wait_ready(1, "t3_ready");
        check("t3_left52", cards_left1, 52);
        diff = 0;
        for (int k = 0; k < 52; k++) begin
            deal(1, v, r, val);
            check("t3_valid", v, 1);
            check("t3_rank", r, exp1[k]);
            check("t3_value", val, value_of(exp1[k]));
            cnt[r]++;
            if (int'(r) != k % 13 + 1) diff = 1;
        end
        for (int k = 1; k <= 13; k++) check("t3_rank_count", cnt[k], 4);
        check("t3_shuffled", diff, 1);
        check("t3_left0", cards_left1, 0);
        deal(1, v, r, val);
        check("t3_exh_novalid", v, 0);
        check("t3_exh_busy", busy1, 1);
        check("t3_exh_left", cards_left1, 52);
        n = 0;
        while (!card_valid1 && n < 2000) begin
            step();
            n++;
        end
        check("t3_exh_valid", card_valid1, 1);
        check("t3_exh_rank", card_rank1, exp2[0]);
        check("t3_exh_left51", cards_left1, 51);
        vcount = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            vcount += int'(card_valid1);
        end
        check("t3_exh_single", vcount, 0);

        // 6: asynchronous reset mid-SHUFFLE, then identical replay
        shuffle_req1 = 1'b1;
        step();
        shuffle_req1 = 1'b0;
        for (int k = 0; k < 60; k++) step();
        check("t6_busy_pre", busy1, 1);
        #3;
        rst1_n = 1'b0;
        #1;
        check("t6_async_rank", card_rank1, 0);
        check("t6_async_value", card_value1, 0);
        check("t6_async_valid", card_valid1, 0);
        check("t6_async_ready", ready1, 0);
        check("t6_async_left", cards_left1, 52);
        check("t6_async_busy", busy1, 1);
        step(); step();
        rst1_n = 1'b1;
        wait_ready(1, "t6_ready");
        for (int k = 0; k < 5; k++) begin
            deal(1, v, r, val);
            check("t6_valid", v, 1);
            check("t6_rank", r, exp1[k]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
